// File: rtl/txepad_pkg.sv
// Shared net definitions: minimum frame length and the pad FSM state encoding,
// common to the transmit padder and the receive-side minimum-length check.
package txepad_pkg;

    localparam int NET_MINBYTES = 60;
    localparam int BYTE_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } padState_t;

endpackage

// File: rtl/txepad_if.sv
// Byte stream with valid/ready handshake, last marker and frame-abort flag.
interface txepad_if;
    import txepad_pkg::*;

    logic              valid;
    logic              ready;
    logic [BYTE_W-1:0] data;
    logic              last;
    logic              abort;

    modport master (output valid, output data, output last, output abort, input ready);
    modport slave  (input valid, input data, input last, input abort, output ready);

endinterface

// File: rtl/txepad.sv
// Transmit padder: forwards frames through a one-beat output register and
// appends zero bytes so every enabled frame reaches MINBYTES before its LAST.
module txepad
    import txepad_pkg::*;
#(
    parameter int MINBYTES = NET_MINBYTES
) (
    input  logic     i_clk,
    input  logic     i_reset,
    input  logic     i_en,
    txepad_if.slave  sAxin,
    txepad_if.master mAxin
);

    localparam int LGNCOUNT = $clog2(MINBYTES + 2);
    localparam int CW       = LGNCOUNT + 1;
    localparam logic [CW-1:0] NSAT = CW'(2 ** LGNCOUNT);

    padState_t         state_q, state_d;
    logic [CW-1:0]     ncnt_q, ncnt_d;
    logic              en_q, en_d;
    logic              mValid_q, mValid_d;
    logic [BYTE_W-1:0] mData_q, mData_d;
    logic              mLast_q, mLast_d;
    logic              mAbort_q, mAbort_d;

    logic              outFree;
    logic              aborting;
    logic              sReady;
    logic              accept;
    logic              enNow;
    logic              reachedMin;
    logic [CW-1:0]     ncntInc;

    assign outFree    = !mValid_q || mAxin.ready;
    assign aborting   = (state_q == DATA) && sAxin.abort;
    // An outstanding abort blocks new beats until the sink has seen it.
    assign sReady     = (state_q != PAD) && outFree && (!mAbort_q || mAxin.ready) && !aborting;
    assign accept     = sAxin.valid && sReady;
    assign enNow      = (state_q == IDLE) ? i_en : en_q;
    assign reachedMin = (int'(ncnt_q) + 1) >= MINBYTES;
    assign ncntInc    = (ncnt_q == NSAT) ? ncnt_q : ncnt_q + CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            ncnt_q   <= '0;
            en_q     <= 1'b0;
            mValid_q <= 1'b0;
            mData_q  <= '0;
            mLast_q  <= 1'b0;
            mAbort_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ncnt_q   <= ncnt_d;
            en_q     <= en_d;
            mValid_q <= mValid_d;
            mData_q  <= mData_d;
            mLast_q  <= mLast_d;
            mAbort_q <= mAbort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ncnt_d   = ncnt_q;
        en_d     = en_q;
        mValid_d = mValid_q && !mAxin.ready;
        mData_d  = mData_q;
        mLast_d  = mLast_q;
        mAbort_d = mAbort_q && !mAxin.ready;

        unique case (state_q)
            IDLE, DATA: begin
                if (state_q == IDLE) begin
                    ncnt_d = '0;
                end
                if (aborting) begin
                    mValid_d = 1'b0;
                    mLast_d  = 1'b0;
                    mAbort_d = 1'b1;
                    ncnt_d   = '0;
                    state_d  = IDLE;
                end else if (accept) begin
                    mValid_d = 1'b1;
                    mData_d  = sAxin.data;
                    ncnt_d   = ncntInc;
                    if (state_q == IDLE) begin
                        en_d = i_en;
                    end
                    // A short final beat hands over to PAD instead of closing the frame.
                    if (!sAxin.last) begin
                        mLast_d = 1'b0;
                        state_d = DATA;
                    end else if (reachedMin || !enNow) begin
                        mLast_d = 1'b1;
                        ncnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        mLast_d = 1'b0;
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                if (outFree) begin
                    mValid_d = 1'b1;
                    mData_d  = '0;
                    ncnt_d   = ncntInc;
                    if (int'(ncnt_q) == MINBYTES - 1) begin
                        mLast_d = 1'b1;
                        ncnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        mLast_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sAxin.ready = sReady;
    assign mAxin.valid = mValid_q;
    assign mAxin.data  = mData_q;
    assign mAxin.last  = mLast_q;
    assign mAxin.abort = mAbort_q;

endmodule

// File: tb/tb_txepad.sv
// Scoreboard bench for txepad: a frame model queues expected {last,data}
// words as frames are driven; a monitor pops them as output beats transfer.
module tb_txepad;
    import txepad_pkg::*;

    localparam int MINB = NET_MINBYTES;

    logic clk = 1'b0;
    logic rst;
    logic iEn;

    txepad_if sIf ();
    txepad_if mIf ();

    txepad #(.MINBYTES(MINB)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_en   (iEn),
        .sAxin  (sIf),
        .mAxin  (mIf)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] sbQ[$];
    bit         sbEnable    = 1'b1;
    int         bpMode      = 0;
    bit         forcedReady = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Sink readiness: always ready, random 50%, or held by the main sequence.
    always @(posedge clk) begin
        #1;
        case (bpMode)
            0:       mIf.ready = 1'b1;
            1:       mIf.ready = ($urandom_range(0, 1) == 1);
            default: mIf.ready = forcedReady;
        endcase
    end

    logic [8:0] prevWord;
    bit         prevStall = 1'b0;
    logic [8:0] expWord;

    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall && mIf.valid) begin
                checkOutput("hold", {23'd0, mIf.last, mIf.data}, {23'd0, prevWord});
            end
            if (sbEnable && mIf.valid && mIf.ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("extra", {31'd0, mIf.valid}, 32'd0);
                end else begin
                    expWord = sbQ.pop_front();
                    checkOutput("byte", {23'd0, mIf.last, mIf.data}, {23'd0, expWord});
                end
            end
            prevStall = mIf.valid && !mIf.ready;
            prevWord  = {mIf.last, mIf.data};
        end
    end

    task automatic waitAccept();
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sIf.ready) break;
        end
        if (n == 400) checkOutput("acceptWait", {31'd0, sIf.ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int len, input bit en, input logic [7:0] base);
        iEn = en;
        if (sbEnable) begin
            for (int i = 0; i < len; i++) begin
                logic l;
                l = (i == len - 1) && (len >= MINB || !en);
                sbQ.push_back({l, 8'(base + i)});
            end
            if (en && len < MINB) begin
                for (int i = len; i < MINB; i++) sbQ.push_back({(i == MINB - 1), 8'h00});
            end
        end
        for (int i = 0; i < len; i++) begin
            sIf.valid = 1'b1;
            sIf.data  = 8'(base + i);
            sIf.last  = (i == len - 1);
            sIf.abort = 1'b0;
            waitAccept();
        end
        sIf.valid = 1'b0;
        sIf.last  = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int budget, input bit toggleEn);
        int n;
        for (n = 0; n < budget && sbQ.size() != 0; n++) begin
            @(posedge clk);
            #1;
            if (toggleEn) iEn = ~iEn;
        end
        checkOutput(tag, sbQ.size(), 32'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic countPadCycles(input string tag, input int expected);
        int n;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sIf.ready) break;
        end
        checkOutput(tag, n, expected);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        iEn       = 1'b0;
        sIf.valid = 1'b0;
        sIf.data  = 8'h00;
        sIf.last  = 1'b0;
        sIf.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstValid", {31'd0, mIf.valid}, 32'd0);
        checkOutput("rstLast",  {31'd0, mIf.last},  32'd0);
        checkOutput("rstAbort", {31'd0, mIf.abort}, 32'd0);
        checkOutput("rstData",  {24'd0, mIf.data},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterReset", {31'd0, sIf.ready}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] short enabled frame is padded");
        applyStimulus(10, 1'b1, 8'h01);
        countPadCycles("padReadyLow", 50);
        @(posedge clk);
        #1;
        waitDrain("drainPad", 200, 1'b0);

        $display("[TB] full-length frame passes unchanged");
        applyStimulus(60, 1'b1, 8'h40);
        @(negedge clk);
        checkOutput("noPad", {31'd0, sIf.ready}, 32'd1);
        @(posedge clk);
        #1;
        waitDrain("drainFull", 100, 1'b0);

        $display("[TB] padding disabled");
        applyStimulus(10, 1'b0, 8'h80);
        waitDrain("drainNoPad", 100, 1'b0);

        $display("[TB] abort mid-frame");
        iEn         = 1'b1;
        forcedReady = 1'b1;
        bpMode      = 2;
        for (int i = 0; i < 4; i++) sbQ.push_back({1'b0, 8'(8'h20 + i)});
        for (int i = 0; i < 4; i++) begin
            sIf.valid = 1'b1;
            sIf.data  = 8'(8'h20 + i);
            sIf.last  = 1'b0;
            sIf.abort = 1'b0;
            waitAccept();
        end
        sIf.data = 8'h24;
        @(negedge clk);
        checkOutput("beat4Ready", {31'd0, sIf.ready}, 32'd1);
        forcedReady = 1'b0;
        @(posedge clk);
        #1;
        sIf.abort = 1'b1;
        @(negedge clk);
        checkOutput("abortBlocksReady", {31'd0, sIf.ready}, 32'd0);
        @(posedge clk);
        #1;
        sIf.valid = 1'b0;
        sIf.abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abortHeld",    {31'd0, mIf.abort}, 32'd1);
            checkOutput("abortNoValid", {31'd0, mIf.valid}, 32'd0);
        end
        forcedReady = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abortAtReady", {31'd0, mIf.abort}, 32'd1);
        @(negedge clk);
        checkOutput("abortCleared", {31'd0, mIf.abort}, 32'd0);
        @(posedge clk);
        #1;
        bpMode = 0;
        checkOutput("drainAbort", sbQ.size(), 32'd0);
        applyStimulus(10, 1'b1, 8'h30);
        countPadCycles("padAfterAbort", 50);
        @(posedge clk);
        #1;
        waitDrain("drainAfterAbort", 200, 1'b0);

        $display("[TB] single byte under random backpressure");
        bpMode = 1;
        applyStimulus(1, 1'b1, 8'hA5);
        waitDrain("drainBp", 2000, 1'b1);
        bpMode = 0;

        $display("[TB] long frame then reset during padding");
        applyStimulus(200, 1'b1, 8'h10);
        waitDrain("drainLong", 300, 1'b0);
        sbEnable = 1'b0;
        applyStimulus(10, 1'b1, 8'h55);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("inPad", {31'd0, sIf.ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRstValid", {31'd0, mIf.valid}, 32'd0);
        checkOutput("postRstLast",  {31'd0, mIf.last},  32'd0);
        checkOutput("postRstAbort", {31'd0, mIf.abort}, 32'd0);
        checkOutput("postRstReady", {31'd0, sIf.ready}, 32'd1);
        @(posedge clk);
        #1;
        sbEnable = 1'b1;
        applyStimulus(5, 1'b0, 8'hC0);
        waitDrain("drainPostRst", 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
